// File: rtl/fir_pkg.sv
// Shared constants for the FIR accelerator control block: register map,
// ap_ctrl bit positions and the AXI-Lite write/read FSM encodings.
package fir_pkg;

    localparam int AP_CTRL  = 'h00;
    localparam int DATA_LEN = 'h10;
    localparam int TAP_BASE = 'h40;

    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;
    localparam int AP_IDLE  = 2;

    localparam logic [31:0] BUSY_RDATA = 32'hFFFF_FFFF;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/fir_tap_port_mux.sv
// Tap RAM port select: the engine owns the port while a run is in progress,
// otherwise the AXI-Lite side drives it.
module fir_tap_port_mux #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   busy,
    input  logic                   axi_en,
    input  logic [3:0]             axi_we,
    input  logic [pADDR_WIDTH-1:0] axi_a,
    input  logic [pDATA_WIDTH-1:0] axi_di,
    input  logic                   eng_en,
    input  logic [pADDR_WIDTH-1:0] eng_a,
    output logic                   tap_en,
    output logic [3:0]             tap_we,
    output logic [pADDR_WIDTH-1:0] tap_a,
    output logic [pDATA_WIDTH-1:0] tap_di
);

    always_comb begin
        tap_di = axi_di;
        if (busy) begin
            tap_en = eng_en;
            tap_we = 4'h0;
            tap_a  = eng_a;
        end else begin
            tap_en = axi_en;
            tap_we = axi_we;
            tap_a  = axi_a;
        end
    end

endmodule

// File: rtl/fir_axilite_ctrl.sv
// AXI-Lite slave for the FIR accelerator: ap_ctrl start/done/idle handshake,
// data_length register and CPU access to the tap coefficient RAM.
module fir_axilite_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   eng_tap_EN,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic [pDATA_WIDTH-1:0] eng_tap_Do,
    output logic                   engine_start,
    input  logic                   engine_done,
    output logic [pDATA_WIDTH-1:0] data_length
);

    localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(DATA_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAP     = pADDR_WIDTH'(TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_END = pADDR_WIDTH'(TAP_BASE + 4 * Tape_Num);

    w_state_t               w_state;
    r_state_t               r_state;
    logic [pADDR_WIDTH-1:0] w_addr;
    logic [pADDR_WIDTH-1:0] r_addr;
    logic [pDATA_WIDTH-1:0] w_data;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic [pDATA_WIDTH-1:0] reg_rdata;
    logic                   ap_start;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   rd_live;
    logic                   w_tap_hit;
    logic                   r_tap_hit;
    logic                   rd_stall;
    logic                   rd_ctrl_hs;
    logic                   axi_en;
    logic [3:0]             axi_we;
    logic [pADDR_WIDTH-1:0] axi_a;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_TAP) && (a < A_TAP_END) && (a[1:0] == 2'b00);
    endfunction

    // A tap write and tap read landing in the same cycle: the write keeps the port.
    assign w_tap_hit  = (w_state == W_RESP) && is_tap(w_addr) && ap_idle;
    assign r_tap_hit  = (r_state == R_ADDR) && is_tap(r_addr) && ap_idle;
    assign rd_stall   = w_tap_hit && r_tap_hit;
    assign arready    = (r_state == R_ADDR) && !rd_stall;
    assign rd_ctrl_hs = (r_state == R_DATA) && rvalid && rready && (r_addr == A_CTRL);

    assign axi_en     = w_tap_hit || r_tap_hit;
    assign axi_we     = w_tap_hit ? 4'hF : 4'h0;
    assign axi_a      = (w_tap_hit ? w_addr : r_addr) - A_TAP;
    assign eng_tap_Do = tap_Do;

    // RAM data arrives in the first R_DATA cycle; it is forwarded then held.
    assign rdata = rd_live ? tap_Do : rdata_q;

    always_comb begin
        reg_rdata = '0;
        if (r_addr == A_CTRL) begin
            reg_rdata[AP_START] = ap_start;
            reg_rdata[AP_DONE]  = ap_done;
            reg_rdata[AP_IDLE]  = ap_idle;
        end else if (r_addr == A_LEN) begin
            reg_rdata = data_length;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_data  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && wvalid) begin
                        w_state <= W_RESP;
                        w_addr  <= awaddr;
                        w_data  <= wdata;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    w_state <= W_IDLE;
                    awready <= 1'b0;
                    wready  <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_start     <= 1'b0;
            ap_done      <= 1'b0;
            ap_idle      <= 1'b1;
            engine_start <= 1'b0;
            data_length  <= '0;
        end else begin
            engine_start <= 1'b0;
            if (ap_start) begin
                ap_start     <= 1'b0;
                ap_idle      <= 1'b0;
                engine_start <= 1'b1;
            end
            if (w_state == W_RESP && ap_idle) begin
                if (w_addr == A_CTRL && w_data[AP_START] && !ap_start)
                    ap_start <= 1'b1;
                if (w_addr == A_LEN)
                    data_length <= w_data;
            end
            if (rd_ctrl_hs)
                ap_done <= 1'b0;
            // Placed last so a run completion beats a coinciding clear-on-read.
            if (engine_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            rvalid  <= 1'b0;
            rdata_q <= '0;
            rd_live <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_state <= R_ADDR;
                        r_addr  <= araddr;
                    end
                end
                R_ADDR: begin
                    if (!rd_stall) begin
                        r_state <= R_DATA;
                        rvalid  <= 1'b1;
                        if (!is_tap(r_addr))
                            rdata_q <= reg_rdata;
                        else if (ap_idle)
                            rd_live <= 1'b1;
                        else
                            rdata_q <= pDATA_WIDTH'(BUSY_RDATA);
                    end
                end
                R_DATA: begin
                    rd_live <= 1'b0;
                    if (rd_live)
                        rdata_q <= tap_Do;
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    fir_tap_port_mux #(
        .pADDR_WIDTH(pADDR_WIDTH),
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_tap_mux (
        .busy  (!ap_idle),
        .axi_en(axi_en),
        .axi_we(axi_we),
        .axi_a (axi_a),
        .axi_di(w_data),
        .eng_en(eng_tap_EN),
        .eng_a (eng_tap_A),
        .tap_en(tap_EN),
        .tap_we(tap_WE),
        .tap_a (tap_A),
        .tap_di(tap_Di)
    );

endmodule

// File: tb/tb_fir_axilite_ctrl.sv
// Bench for fir_axilite_ctrl: AXI-Lite drivers, a tap RAM model, a register
// reference model and queue-based monitors for read data and tap writes.
`timescale 1ns/1ps
module tb_fir_axilite_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid, wvalid, arvalid, rready;
    logic          awready, wready, arready, rvalid;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    tap_WE;
    logic          tap_EN;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Di;
    logic [DW-1:0] tap_Do = '0;
    logic          eng_tap_EN;
    logic [AW-1:0] eng_tap_A;
    logic [DW-1:0] eng_tap_Do;
    logic          engine_start, engine_done;
    logic [DW-1:0] data_length;

    always #5 clk = ~clk;

    fir_axilite_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do),
        .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A), .eng_tap_Do(eng_tap_Do),
        .engine_start(engine_start), .engine_done(engine_done), .data_length(data_length)
    );

    // Tap RAM: byte address, read-first, one-cycle registered read data
    logic [DW-1:0] ram [0:1023] = '{default: '0};
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) ram[tap_A[11:2]] <= tap_Di;
            tap_Do <= ram[tap_A[11:2]];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the register block
    logic [DW-1:0] m_tap [NT];
    logic [DW-1:0] m_len;
    logic          m_done, m_idle;
    int            m_starts = 0;

    logic [DW-1:0]      exp_q [$];
    logic [4+AW+DW-1:0] tw_q  [$];

    function automatic bit in_taps(input int ai);
        return ai >= 'h40 && ai < 'h40 + 4 * NT && (ai % 4) == 0;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        int ai = int'(a);
        if (ai == 0) return {29'b0, m_idle, m_done, 1'b0};
        if (ai == 'h10) return m_len;
        if (in_taps(ai)) return m_idle ? m_tap[(ai - 'h40) / 4] : 32'hFFFF_FFFF;
        return '0;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int ai = int'(a);
        if (ai == 0) begin
            if (d[0] && m_idle) begin
                m_idle = 1'b0;
                m_starts++;
            end
        end else if (ai == 'h10) begin
            if (m_idle) m_len = d;
        end else if (in_taps(ai) && m_idle) begin
            m_tap[(ai - 'h40) / 4] = d;
            tw_q.push_back({4'hF, a - 12'h040, d});
        end
    endtask

    task automatic model_reset();
        m_len  = '0;
        m_done = 1'b0;
        m_idle = 1'b1;
    endtask

    // Read monitor: rdata must match the expected head while rvalid is up
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got rdata %0h with nothing expected", rdata);
            end else begin
                chk("rdata", rdata, exp_q[0]);
                if (rready) void'(exp_q.pop_front());
            end
        end
    end

    // Tap write monitor
    always @(negedge clk) begin
        if (rst_n && tap_WE != 4'h0) begin
            if (tw_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tap_write_unexpected: got WE %0h A %0h Di %0h", tap_WE, tap_A, tap_Di);
            end else begin
                chk("tap_write", {tap_WE, tap_A, tap_Di}, tw_q.pop_front());
            end
        end
    end

    int start_cnt  = 0;
    int start_wide = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (engine_start) start_cnt++;
            if (engine_start && prev_start) start_wide++;
            prev_start = engine_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int skew, input bit aw_first);
        int n = 0;
        @(posedge clk); #1;
        awaddr = a;
        wdata  = d;
        if (skew == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end else begin
            if (aw_first) awvalid = 1'b1;
            else wvalid = 1'b1;
            repeat (skew) @(posedge clk);
            #1;
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end
        while (!(awready && wready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("write_timeout", 1, 0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int exp_lat,
                              input int hold, input bit pulse_done);
        int n = 0;
        bit got_ar = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        rready  = (hold == 0);
        while (!rvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (got_ar) arvalid = 1'b0;
            if (arready) got_ar = 1'b1;
        end
        arvalid = 1'b0;
        if (n >= 50) begin
            chk("read_timeout", 1, 0);
            rready = 1'b1;
            return;
        end
        if (exp_lat != 0) chk("rvalid_latency", n, exp_lat);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            rready = 1'b1;
            if (pulse_done) engine_done = 1'b1;
            @(posedge clk); #1;
            engine_done = 1'b0;
        end
        n = 0;
        while (rvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("rvalid_stuck", 1, 0);
        rready = 1'b1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        model_write(a, d);
        drive_write(a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int hold, input bit pulse_done);
        drive_read(a, model_read(a), 2, hold, pulse_done);
        if (pulse_done) begin
            m_done = 1'b1;
            m_idle = 1'b1;
        end else if (a == 12'h000) begin
            m_done = 1'b0;
        end
    endtask

    task automatic engine_finish();
        @(posedge clk); #1;
        engine_done = 1'b1;
        @(posedge clk); #1;
        engine_done = 1'b0;
        m_done = 1'b1;
        m_idle = 1'b1;
    endtask

    task automatic engine_port_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            eng_tap_EN = 1'($urandom_range(0, 1));
            eng_tap_A  = AW'($urandom_range(0, NT - 1)) << 2;
            #2;
            chk("busy_tap_A", tap_A, eng_tap_A);
            chk("busy_tap_EN", tap_EN, eng_tap_EN);
            chk("busy_tap_WE", tap_WE, 4'h0);
            chk("eng_tap_Do", eng_tap_Do, tap_Do);
        end
        @(posedge clk); #1;
        eng_tap_EN = 1'b0;
    endtask

    task automatic random_ops(input int n);
        logic [AW-1:0] bogus [5] = '{12'h004, 12'h020, 12'h06C, 12'h100, 12'h03C};
        int            op, idx;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            op  = $urandom_range(0, 6);
            idx = $urandom_range(0, NT - 1);
            d   = $urandom;
            case (op)
                0: axi_write(AW'('h40 + 4 * idx), d);
                1: axi_read(AW'('h40 + 4 * idx), 0, 1'b0);
                2: axi_write(12'h010, d);
                3: axi_read(12'h010, 0, 1'b0);
                4: axi_write(12'h000, d & ~32'h1);
                5: axi_write(bogus[idx % 5], d);
                default: axi_read(bogus[idx % 5], 0, 1'b0);
            endcase
        end
    endtask

    task automatic read_then_reset(input logic [AW-1:0] a);
        int n = 0;
        bit got_ar = 1'b0;
        exp_q.push_back(model_read(a));
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b0;
        while (!rvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (got_ar) arvalid = 1'b0;
            if (arready) got_ar = 1'b1;
        end
        arvalid = 1'b0;
        chk("abort_rvalid_latency", n, 2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_rvalid", rvalid, 1'b0);
        chk("reset_arready", arready, 1'b0);
        chk("reset_rdata", rdata, '0);
        chk("reset_data_length", data_length, '0);
        exp_q.delete();
        tw_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rready = 1'b1;
    endtask

    logic [DW-1:0] coef [NT];

    initial begin
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 1;
        awaddr = '0; araddr = '0; wdata = '0;
        eng_tap_EN = 0; eng_tap_A = '0; engine_done = 0;
        for (int i = 0; i < NT; i++) m_tap[i] = '0;
        model_reset();
        coef = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_engine_start", engine_start, 0);
        chk("rst_tap_EN", tap_EN, 0);
        chk("rst_tap_WE", tap_WE, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_data_length", data_length, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        axi_read(12'h000, 0, 1'b0);

        for (int i = 0; i < NT; i++) axi_write(AW'('h40 + 4 * i), coef[i]);
        for (int i = 0; i < NT; i++) axi_read(AW'('h40 + 4 * i), 0, 1'b0);

        random_ops(40);

        // Same-cycle tap write and tap read, then tap write with register read
        model_write(12'h054, 32'hA5A5_0001);
        fork
            drive_write(12'h054, 32'hA5A5_0001, 0, 1'b1);
            drive_read(12'h054, model_read(12'h054), 3, 0, 1'b0);
        join
        model_write(12'h05C, 32'h0BAD_F00D);
        fork
            drive_write(12'h05C, 32'h0BAD_F00D, 0, 1'b1);
            drive_read(12'h010, model_read(12'h010), 2, 0, 1'b0);
        join

        axi_write(12'h000, 32'h6);
        axi_read(12'h000, 0, 1'b0);
        repeat (3) @(posedge clk);
        chk("no_start_bit0_clear", start_cnt, m_starts);

        // Start a run
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'h1);
        repeat (4) @(posedge clk);
        chk("start_count", start_cnt, m_starts);
        chk("data_length_port", data_length, 32'd600);
        axi_read(12'h010, 0, 1'b0);
        axi_read(12'h000, 0, 1'b0);
        axi_write(12'h000, 32'h1);
        repeat (4) @(posedge clk);
        chk("busy_start_ignored", start_cnt, m_starts);

        axi_write(12'h044, 32'h1234);
        axi_read(12'h044, 0, 1'b0);
        axi_write(12'h010, 32'd7);
        axi_read(12'h010, 0, 1'b0);
        random_ops(10);
        engine_port_check(8);
        chk("ram_tap1_unchanged", ram[1], m_tap[1]);

        engine_finish();
        axi_read(12'h000, 0, 1'b0);
        axi_read(12'h000, 0, 1'b0);
        axi_read(12'h044, 0, 1'b0);

        // engine_done coinciding with the clearing handshake
        axi_write(12'h000, 32'h1);
        repeat (3) @(posedge clk);
        engine_finish();
        axi_read(12'h000, 2, 1'b1);
        axi_read(12'h000, 0, 1'b0);
        axi_read(12'h000, 0, 1'b0);
        chk("start_count_2", start_cnt, m_starts);

        random_ops(30);

        // Reset during R_DATA while busy
        axi_write(12'h000, 32'h1);
        repeat (4) @(posedge clk);
        read_then_reset(12'h000);
        repeat (2) @(posedge clk);
        axi_read(12'h000, 0, 1'b0);
        axi_read(12'h010, 0, 1'b0);
        axi_read(12'h044, 0, 1'b0);
        chk("start_count_final", start_cnt, m_starts);

        repeat (4) @(posedge clk);
        chk("read_queue_drained", exp_q.size(), 0);
        chk("tap_write_queue_drained", tw_q.size(), 0);
        chk("start_pulse_width", start_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fir_axilite_ctrl.md
Name: fir_axilite_ctrl

Overview:
- AXI-Lite slave and configuration/control register block inside the FIR accelerator.
- Consumes the AXI-Lite write/read transactions produced by the Wishbone-to-AXI bridge.
- Owns the ap_ctrl handshake (start/done/idle), the data_length register and CPU access to the tap coefficient RAM.
- Hands the tap RAM port to the FIR datapath engine while a run is in progress.

Parameters:
- pADDR_WIDTH, 12: AXI-Lite and tap RAM address width.
- pDATA_WIDTH, 32: data width.
- Tape_Num, 11: number of taps; the tap window holds Tape_Num words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- awaddr  in  pADDR_WIDTH  write address
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  pDATA_WIDTH  write data
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  pADDR_WIDTH  read address
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  pDATA_WIDTH  read data
- tap_WE  out  4  tap RAM byte write enables
- tap_EN  out  1  tap RAM enable
- tap_A  out  pADDR_WIDTH  tap RAM byte address
- tap_Di  out  pDATA_WIDTH  tap RAM write data
- tap_Do  in  pDATA_WIDTH  tap RAM read data; one-cycle registered latency
- eng_tap_EN  in  1  engine tap read enable
- eng_tap_A  in  pADDR_WIDTH  engine tap byte address
- eng_tap_Do  out  pDATA_WIDTH  tap_Do forwarded to the engine
- engine_start  out  1  one-cycle run start pulse
- engine_done  in  1  one-cycle run complete pulse
- data_length  out  pDATA_WIDTH  number of samples per run

Behaviour:
- Address map (byte offsets):
  - 0x00 ap_ctrl: bit0 ap_start (write-1), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO).
  - 0x10 data_length (R/W).
  - 0x40 + 4*i, i < Tape_Num: tap i.
  - All other offsets: reads return 0; writes complete with no effect.
- Reset values:
  - awready, wready, arready, rvalid, engine_start, tap_EN, tap_WE = 0.
  - rdata = 0, data_length = 0, ap_done = 0, ap_idle = 1, ap_start = 0.
- Write FSM, states W_IDLE -> W_RESP -> W_IDLE:
  - W_IDLE: on awvalid & wvalid both high, go to W_RESP. Write with only one valid high: wait.
  - W_RESP: awready = wready = 1 for exactly one cycle; the register or tap write commits in this cycle.
  - Tap write: tap_EN = 1, tap_WE = 4'hF, tap_A = awaddr - 0x40, tap_Di = wdata.
- Read FSM, states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_ADDR: arready = 1 for one cycle; tap reads drive tap_EN = 1, tap_WE = 0, tap_A = araddr - 0x40.
  - R_DATA: rdata is registered from tap_Do or the register value; rvalid = 1 is held until rready; rdata is stable while rvalid & !rready.
  - rvalid rises 2 cycles after arvalid is first sampled.
- Write and read FSMs are independent. A same-cycle tap write and tap read: the write owns the RAM port and the read R_ADDR stalls one cycle.
- Start handshake:
  - Writing wdata[0] = 1 to 0x00 while ap_idle = 1 sets ap_start. Next cycle: engine_start = 1 for one cycle, ap_start clears, ap_idle clears.
  - A start write while ap_idle = 0 is ignored.
  - Writes of wdata[0] = 0 have no effect. Bits 1 and 2 are not writable.
- engine_done pulse: ap_done = 1, ap_idle = 1 in the next cycle.
- ap_done clears on the rvalid & rready handshake of a read of 0x00. If engine_done coincides with that clear, the set wins.
- Busy (ap_idle = 0):
  - Tap RAM port is driven by the engine: tap_EN = eng_tap_EN, tap_A = eng_tap_A, tap_WE = 0.
  - AXI tap writes and data_length writes complete the handshake but are dropped.
  - AXI tap reads return 0xFFFFFFFF.
- eng_tap_Do = tap_Do at all times.
- Reset mid-transaction: both FSMs return to idle, pending responses are lost, ap_idle = 1.

Decomposition:
- Shared package fir_pkg:
  - Register offsets: AP_CTRL 0x00, DATA_LEN 0x10, TAP_BASE 0x40.
  - ap_ctrl bit positions: AP_START 0, AP_DONE 1, AP_IDLE 2.
  - Write and read FSM state encodings.
  - Busy read value 0xFFFFFFFF.
- Optional sub-module fir_tap_port_mux: combinational AXI/engine tap RAM port select. All remaining logic stays in this module.

Test Plan:
- Reset, then read 0x00 -> rdata = 0x4; rvalid rises 2 cycles after arvalid.
- Write taps 0..10 with values 0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, then read back -> identical values; tap_A = 0x00..0x28 and tap_WE = 4'hF on each write.
- Write 600 to 0x10, write 0x1 to 0x00:
  - read 0x10 -> 600.
  - engine_start is a single pulse.
  - read 0x00 -> 0x0.
  - a second start write -> no engine_start.
- While busy:
  - write 0x1234 to 0x44 -> tap RAM unchanged.
  - read 0x44 -> 0xFFFFFFFF.
  - tap_A follows eng_tap_A.
- Pulse engine_done:
  - read 0x00 -> 0x6.
  - read again -> 0x4.
  - engine_done in the same cycle as the clearing handshake -> next read 0x6.
- Assert rst_n low during R_DATA with rready = 0 -> rvalid = 0 and ap_idle = 1 immediately; the next read works normally.
